// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
// The misalignment helper is only called when DMEM_ARB_MISALIGN_CHK_EN is defined.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Byte accesses can never be misaligned; halfwords need addr[0]=0, words addr[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic byte_acc;
        logic half_acc;
        logic word_acc;
        byte_acc = (f3 == F3_SB) || (f3 == F3_LB) || (f3 == F3_LBU);
        half_acc = (f3 == F3_SH) || (f3 == F3_LH) || (f3 == F3_LHU);
        word_acc = (f3 == F3_SW) || (f3 == F3_LW);
        return !byte_acc && ((half_acc && addr_lo[0]) || (word_acc && (addr_lo != 2'b00)));
    endfunction

endpackage

// File: rtl/dmem_arb_rr2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to rr_ptr_i.
module dmem_arb_rr2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       rr_ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = rr_ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between port 0 (LSU) and port 1 (DMA/debug) with lockable bursts.
// Define DMEM_ARB_MISALIGN_CHK_EN to suppress and flag misaligned halfword/word beats.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p0_we,
    input  logic                  p0_lock,
    input  logic [2:0]            p0_funct3,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_err,

    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic                  p1_we,
    input  logic                  p1_lock,
    input  logic [2:0]            p1_funct3,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_err,

    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

    arb_state_e            state_q, state_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]      cnt_inc;
    logic [1:0]            gnt;
    logic                  beat0, beat1, beat;
    logic                  sel_we, sel_lock, mis;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    dmem_arb_rr2 u_rr2 (
        .req_i    ({p1_valid, p0_valid}),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (gnt)
    );

    // Grant and accept happen in the same cycle; a locked owner excludes the other port.
    always_comb begin
        p0_ready = 1'b0;
        p1_ready = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    p0_ready = gnt[0];
                    p1_ready = gnt[1];
                end
                OWN0:    p0_ready = p0_valid;
                OWN1:    p1_ready = p1_valid;
                default: ;
            endcase
        end
    end

    assign beat0 = p0_valid & p0_ready;
    assign beat1 = p1_valid & p1_ready;
    assign beat  = beat0 | beat1;

    always_comb begin
        mem_funct3 = beat1 ? p1_funct3 : p0_funct3;
        mem_addr   = beat1 ? p1_addr   : p0_addr;
        mem_wdata  = beat1 ? p1_wdata  : p0_wdata;
        sel_we     = beat1 ? p1_we     : p0_we;
        sel_lock   = beat1 ? p1_lock   : p0_lock;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
        mis        = beat & is_misaligned(mem_funct3, mem_addr[1:0]);
`else
        mis        = 1'b0;
`endif
        mem_wr_en  = beat & sel_we & ~mis;
    end

    // Ownership is kept only while the owner issues locked beats and the burst cap is not reached.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        cnt_inc    = beat_cnt_q + CNT_W'(1);
        if (beat) begin
            if (state_q == IDLE) begin
                rr_ptr_d = ~beat1;
            end
            if (sel_lock && (cnt_inc < BURST_LIM)) begin
                state_d    = beat1 ? OWN1 : OWN0;
                beat_cnt_d = cnt_inc;
            end else begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        end else begin
            state_d    = IDLE;
            beat_cnt_d = '0;
        end
    end

    always_comb begin
        rvalid0_d = beat0;
        rvalid1_d = beat1;
        rdata_d   = (beat & ~sel_we & ~mis) ? mem_rd_data : '0;
        err_d     = mis;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            beat_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // One shared response register; only the port that owned the beat sees it.
    assign p0_rvalid = rvalid0_q;
    assign p1_rvalid = rvalid1_q;
    assign p0_rdata  = rvalid0_q ? rdata_q : '0;
    assign p1_rdata  = rvalid1_q ? rdata_q : '0;
    assign p0_err    = rvalid0_q & err_q;
    assign p1_err    = rvalid1_q & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_dmem_arbiter;

    localparam int BM = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_valid, p0_ready, p0_we, p0_lock, p0_rvalid, p0_err;
    logic [2:0]  p0_funct3;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_valid, p1_ready, p1_we, p1_lock, p1_rvalid, p1_err;
    logic [2:0]  p1_funct3;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_wr_en;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wdata, mem_rd_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_MAX(BM)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_lock(p0_lock),
        .p0_funct3(p0_funct3), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_lock(p1_lock),
        .p1_funct3(p1_funct3), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rd_data(mem_rd_data)
    );

    // Word-wide memory stub: combinational read, write at the clock edge.
    logic [31:0] stubMem [16];
    bit          stubInit = 1'b0;
    assign mem_rd_data = stubMem[mem_addr[5:2]];
    always @(posedge clk) begin
        if (!stubInit) begin
            for (int i = 0; i < 16; i++) stubMem[i] <= 32'h1000_0000 + i;
            stubInit <= 1'b1;
        end else if (mem_wr_en) begin
            stubMem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: owner is -1 when nobody holds the memory.
    int          mOwner = -1;
    int          mBeats = 0;
    bit          mRr = 1'b0;
    bit          pendV = 1'b0;
    int          pendPort = 0;
    logic [31:0] pendD = '0;
    bit          pendE = 1'b0;
    logic [31:0] mMem [16];
    bit          mInit = 1'b0;

    always @(negedge clk) begin
        int          g;
        logic [2:0]  f3;
        logic [31:0] a, d;
        bit          we, lk, mis, expWr;
        if (!mInit) begin
            for (int i = 0; i < 16; i++) mMem[i] = 32'h1000_0000 + i;
            mInit = 1'b1;
        end
        checkOutput("m_rvalid0", p0_rvalid, pendV && pendPort == 0);
        checkOutput("m_rvalid1", p1_rvalid, pendV && pendPort == 1);
        if (pendV) begin
            checkOutput("m_rdata", pendPort == 1 ? p1_rdata : p0_rdata, pendD);
            checkOutput("m_err", pendPort == 1 ? p1_err : p0_err, pendE);
        end
        g = -1;
        if (rst_n) begin
            if (mOwner < 0) begin
                if (p0_valid && p1_valid) g = mRr ? 1 : 0;
                else if (p0_valid) g = 0;
                else if (p1_valid) g = 1;
            end else if (mOwner == 0 && p0_valid) begin
                g = 0;
            end else if (mOwner == 1 && p1_valid) begin
                g = 1;
            end
        end
        f3 = (g == 1) ? p1_funct3 : p0_funct3;
        a  = (g == 1) ? p1_addr   : p0_addr;
        d  = (g == 1) ? p1_wdata  : p0_wdata;
        we = (g == 1) ? p1_we     : p0_we;
        lk = (g == 1) ? p1_lock   : p0_lock;
        mis = 1'b0;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
        mis = (g >= 0) && ((f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00));
`endif
        expWr = (g >= 0) && we && !mis;
        checkOutput("m_ready0", p0_ready, g == 0);
        checkOutput("m_ready1", p1_ready, g == 1);
        checkOutput("m_wr_en", mem_wr_en, expWr);
        checkOutput("m_funct3", mem_funct3, f3);
        checkOutput("m_addr", mem_addr, a);
        checkOutput("m_wdata", mem_wdata, d);
        if (!rst_n) begin
            mOwner = -1; mBeats = 0; mRr = 1'b0; pendV = 1'b0;
        end else if (g >= 0) begin
            pendV = 1'b1;
            pendPort = g;
            pendE = mis;
            pendD = (we || mis) ? 32'h0 : mMem[a[5:2]];
            if (mOwner < 0) begin
                mRr = (g == 0);
                mBeats = 0;
            end
            mBeats++;
            if (lk && mBeats < BM) mOwner = g;
            else begin
                mOwner = -1;
                mBeats = 0;
            end
            if (expWr) mMem[a[5:2]] = d;
        end else begin
            pendV = 1'b0; mOwner = -1; mBeats = 0;
        end
    end

    task automatic applyStimulus(input int port, input bit v, input bit we, input bit lk,
                                 input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        if (port == 0) begin
            p0_valid = v; p0_we = we; p0_lock = lk; p0_funct3 = f3; p0_addr = a; p0_wdata = d;
        end else begin
            p1_valid = v; p1_we = we; p1_lock = lk; p1_funct3 = f3; p1_addr = a; p1_wdata = d;
        end
    endtask

    task automatic idleBoth();
        applyStimulus(0, 0, 0, 0, 3'b010, 32'h0, 32'h0);
        applyStimulus(1, 0, 0, 0, 3'b010, 32'h0, 32'h0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] f3Tab [5];
        bit         tieExp [4];
        bit         burstExp [7];
        f3Tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        tieExp = '{1'b1, 1'b0, 1'b1, 1'b0};
        burstExp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0;
        idleBoth();
        applyStimulus(0, 1, 0, 0, 3'b010, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("rst_ready0", p0_ready, 0);
        checkOutput("rst_rvalid0", p0_rvalid, 0);
        nextCycle();
        rst_n = 1'b1;

        // Single store then load of the same word
        idleBoth();
        applyStimulus(0, 1, 1, 0, 3'b010, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("t1_sw_ready", p0_ready, 1);
        checkOutput("t1_sw_wr_en", mem_wr_en, 1);
        nextCycle();
        applyStimulus(0, 1, 0, 0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        checkOutput("t1_lw_ready", p0_ready, 1);
        checkOutput("t1_sw_rdata", p0_rdata, 0);
        nextCycle();
        idleBoth();
        @(negedge clk);
        checkOutput("t1_rvalid0", p0_rvalid, 1);
        checkOutput("t1_rdata", p0_rdata, 32'hDEADBEEF);
        checkOutput("t1_rvalid1", p1_rvalid, 0);
        nextCycle();

        // Move the pointer back to port 0, then alternate on a tie
        applyStimulus(1, 1, 0, 0, 3'b010, 32'h4, 32'h0);
        nextCycle();
        applyStimulus(0, 1, 0, 0, 3'b010, 32'h0, 32'h0);
        applyStimulus(1, 1, 0, 0, 3'b010, 32'h8, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t2_ready0", p0_ready, tieExp[i]);
            checkOutput("t2_ready1", p1_ready, !tieExp[i]);
            checkOutput("t2_rvalid0", p0_rvalid, (i == 0) ? 1'b0 : tieExp[i-1]);
            nextCycle();
        end
        idleBoth();

        // Port 1 locked burst capped at BM beats while port 0 waits
        applyStimulus(0, 1, 0, 0, 3'b010, 32'h0, 32'h0);
        nextCycle();
        applyStimulus(1, 1, 0, 1, 3'b010, 32'hC, 32'h0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput("t3_ready1", p1_ready, burstExp[i]);
            checkOutput("t3_ready0", p0_ready, !burstExp[i]);
            nextCycle();
        end
        idleBoth();
        nextCycle();

        // Locked owner goes quiet: ownership released after one idle cycle
        applyStimulus(1, 1, 0, 1, 3'b010, 32'h8, 32'h0);
        @(negedge clk);
        checkOutput("t4_ready1", p1_ready, 1);
        nextCycle();
        idleBoth();
        applyStimulus(0, 1, 0, 0, 3'b010, 32'h4, 32'h0);
        @(negedge clk);
        checkOutput("t4_drop_ready0", p0_ready, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("t4_after_ready0", p0_ready, 1);
        nextCycle();
        idleBoth();
        nextCycle();

        // Reset during the second beat of a port 0 locked burst
        applyStimulus(0, 1, 1, 1, 3'b010, 32'h30, 32'h55);
        nextCycle();
        applyStimulus(0, 1, 1, 1, 3'b010, 32'h34, 32'h66);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t5_ready0", p0_ready, 0);
        checkOutput("t5_wr_en", mem_wr_en, 0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(0, 1, 0, 0, 3'b010, 32'h34, 32'h0);
        applyStimulus(1, 1, 0, 0, 3'b010, 32'h30, 32'h0);
        @(negedge clk);
        checkOutput("t5_rvalid0", p0_rvalid, 0);
        checkOutput("t5_ready0_rr", p0_ready, 1);
        checkOutput("t5_ready1_rr", p1_ready, 0);
        nextCycle();
        idleBoth();
        @(negedge clk);
        checkOutput("t5_no_write", p0_rdata, 32'h1000_000D);
        nextCycle();

        // Misaligned word store
        applyStimulus(0, 1, 1, 0, 3'b010, 32'h20, 32'h11111111);
        nextCycle();
        applyStimulus(0, 1, 1, 0, 3'b010, 32'h22, 32'hCAFEF00D);
        @(negedge clk);
`ifdef DMEM_ARB_MISALIGN_CHK_EN
        checkOutput("t6_wr_en", mem_wr_en, 0);
`else
        checkOutput("t6_wr_en", mem_wr_en, 1);
`endif
        nextCycle();
        applyStimulus(0, 1, 0, 0, 3'b010, 32'h20, 32'h0);
        @(negedge clk);
        checkOutput("t6_rvalid0", p0_rvalid, 1);
        checkOutput("t6_rdata", p0_rdata, 0);
`ifdef DMEM_ARB_MISALIGN_CHK_EN
        checkOutput("t6_err", p0_err, 1);
`else
        checkOutput("t6_err", p0_err, 0);
`endif
        nextCycle();
        idleBoth();
        @(negedge clk);
`ifdef DMEM_ARB_MISALIGN_CHK_EN
        checkOutput("t6_mem_word", p0_rdata, 32'h11111111);
`else
        checkOutput("t6_mem_word", p0_rdata, 32'hCAFEF00D);
`endif
        nextCycle();

        // Randomized traffic, including occasional resets
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            for (int p = 0; p < 2; p++) begin
                applyStimulus(p, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), f3Tab[$urandom_range(0, 4)],
                              32'($urandom_range(0, 63)), $urandom);
            end
            nextCycle();
        end
        rst_n = 1'b1;
        idleBoth();
        repeat (3) nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
